// File: rtl/mux_pipe.sv
// -----------------------------------------------------------------------------
// mux_pipe
//   Two-stage pipelined NUM_IN:1 word multiplexer with valid/ready handshakes
//   on both sides.
//
//   Stage 1 performs the low-order selection. Inputs are split into groups of
//   four, and in_sel[1:0] picks one word from each group. The stage registers
//   all NUM_IN/4 partial words plus the remaining high select bits.
//   Stage 2 uses the registered high select bits to pick the final word from
//   the partial words, and registers it as out_data.
//
//   Latency is two cycles. Throughput is one beat per cycle while out_ready is
//   high. The downstream stall propagates back through in_ready combinationally.
//
// Parameters
//   WIDTH   data width of each input word and of out_data
//   NUM_IN  number of data inputs (4, 8 or 16)
//   SEL_W   select width, log2(NUM_IN)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    flattened inputs; input k is in_data[k*WIDTH +: WIDTH]
//   in_sel     index of the input to forward
//   in_valid   in_data/in_sel are valid this cycle
//   in_ready   block accepts the input this cycle
//   out_data   selected word
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data this cycle
//   xfer_cnt   wrapping count of completed output transfers
// -----------------------------------------------------------------------------
module mux_pipe #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 16,
  parameter int SEL_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             xfer_cnt
);

  localparam int NUM_GRP = NUM_IN / 4;
  // With only one group there are no high select bits; a single-bit field
  // is still declared so the declarations stay legal, and it is tied to zero.
  localparam int HI_W    = (SEL_W > 2) ? SEL_W - 2 : 1;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_part [NUM_GRP];
  logic [HI_W-1:0]  s1_sel_hi;

  logic [WIDTH-1:0] part_next [NUM_GRP];
  logic [HI_W-1:0]  sel_hi_next;
  logic [WIDTH-1:0] grp_word;

  logic in_xfer;
  logic out_xfer;
  logic s1_adv;

  // Handshake terms. Stage 2 can take a word when it is empty or when its
  // current word leaves this cycle. Stage 1 can take a new input when it is
  // empty or when its content moves into stage 2 this cycle. in_ready
  // deliberately ignores in_valid.
  always_comb begin
    s1_adv   = s1_valid && (!out_valid || out_ready);
    in_ready = !s1_valid || !out_valid || out_ready;
    in_xfer  = in_valid && in_ready;
    out_xfer = out_valid && out_ready;
  end

  // First-level selection. Within each group of four inputs, pick the word
  // addressed by the two low select bits.
  always_comb begin
    for (int g = 0; g < NUM_GRP; g++) begin
      part_next[g] = in_data[(4 * g + int'(in_sel[1:0])) * WIDTH +: WIDTH];
    end
  end

  // The high select bits only exist when there is more than one group.
  generate
    if (SEL_W > 2) begin : g_sel_hi
      assign sel_hi_next = in_sel[SEL_W-1:2];
    end else begin : g_sel_hi_none
      assign sel_hi_next = '0;
    end
  endgenerate

  // Second-level selection. Pick the partial word of the group named by the
  // registered high select bits. A single-group build always uses group 0.
  generate
    if (NUM_GRP == 1) begin : g_grp_one
      assign grp_word = s1_part[0];
    end else begin : g_grp_many
      assign grp_word = s1_part[s1_sel_hi];
    end
  endgenerate

  // Stage 1 register. A new input always wins, including when the old content
  // advances in the same cycle, so s1_valid stays high in that case. Otherwise
  // the stage empties once its content has moved on. It holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_sel_hi <= '0;
      for (int g = 0; g < NUM_GRP; g++) begin
        s1_part[g] <= '0;
      end
    end else if (in_xfer) begin
      s1_valid  <= 1'b1;
      s1_sel_hi <= sel_hi_next;
      for (int g = 0; g < NUM_GRP; g++) begin
        s1_part[g] <= part_next[g];
      end
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 / output register. Loading takes priority over draining, so a
  // back-to-back stream keeps out_valid high. While the output is stalled,
  // neither branch fires and out_data/out_valid hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_data  <= grp_word;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

  // Completed output transfer counter; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_xfer) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mux_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_pipe
//   Directed testbench for mux_pipe.
//
//   The main instance uses the default 16-input build, with input k carrying
//   16'h1000+k. Two smaller builds (4 and 8 inputs) use the data patterns
//   16'h2000+k and 16'h3000+k, so that every index can be swept on them.
//   Inputs change 1 time unit after each rising edge, and outputs are sampled
//   at that same point.
// -----------------------------------------------------------------------------
module tb_mux_pipe;

  logic clk;
  logic rst_n;

  // 16-input instance
  logic [16*16-1:0] in_data;
  logic [3:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      xfer_cnt;

  // 4-input instance
  logic [4*16-1:0]  in_data4;
  logic [1:0]       in_sel4;
  logic             in_valid4;
  logic             in_ready4;
  logic [15:0]      out_data4;
  logic             out_valid4;
  logic             out_ready4;
  logic [15:0]      xfer_cnt4;

  // 8-input instance
  logic [8*16-1:0]  in_data8;
  logic [2:0]       in_sel8;
  logic             in_valid8;
  logic             in_ready8;
  logic [15:0]      out_data8;
  logic             out_valid8;
  logic             out_ready8;
  logic [15:0]      xfer_cnt8;

  int checks;
  int fails;

  mux_pipe #(.WIDTH(16), .NUM_IN(16), .SEL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  mux_pipe #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data4),
    .in_sel    (in_sel4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .out_data  (out_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .xfer_cnt  (xfer_cnt4)
  );

  mux_pipe #(.WIDTH(16), .NUM_IN(8), .SEL_W(3)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data8),
    .in_sel    (in_sel8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .out_data  (out_data8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .xfer_cnt  (xfer_cnt8)
  );

  // 100 MHz-style free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive the 16-input instance for one cycle, then advance past the edge
  task automatic applyStimulus(input logic valid, input logic [3:0] sel, input logic ready);
    in_valid  = valid;
    in_sel    = sel;
    out_ready = ready;
    stepCycle();
  endtask

  // One counted comparison
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Hold reset for two edges, then release it
  task automatic resetDut();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    out_ready = 1'b1;
    stepCycle();
    stepCycle();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] expWord;
    int sent;
    int rcvd;
    int cyc;
    int accepted;

    checks     = 0;
    fails      = 0;
    in_valid4  = 1'b0;
    in_sel4    = '0;
    out_ready4 = 1'b1;
    in_valid8  = 1'b0;
    in_sel8    = '0;
    out_ready8 = 1'b1;
    for (int k = 0; k < 16; k++) in_data[k*16 +: 16] = 16'(16'h1000 + k);
    for (int k = 0; k < 4; k++)  in_data4[k*16 +: 16] = 16'(16'h2000 + k);
    for (int k = 0; k < 8; k++)  in_data8[k*16 +: 16] = 16'(16'h3000 + k);

    // ---- reset state ----
    $display("[TB] reset state");
    resetDut();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_xfer_cnt", xfer_cnt, 0);
    checkOutput("rst_in_ready", in_ready, 1);

    // ---- exhaustive select on the 4- and 8-input builds ----
    $display("[TB] small builds exhaustive select");
    for (int i = 0; i < 9; i++) begin
      in_valid4 = (i < 4);
      in_sel4   = 2'(i);
      in_valid8 = (i < 8);
      in_sel8   = 3'(i);
      stepCycle();
      if (i >= 1 && i <= 4) begin
        checkOutput("n4_valid", out_valid4, 1);
        checkOutput("n4_data", out_data4, 32'h2000 + i - 1);
      end
      if (i >= 1) begin
        checkOutput("n8_valid", out_valid8, 1);
        checkOutput("n8_data", out_data8, 32'h3000 + i - 1);
      end
    end
    in_valid4 = 1'b0;
    in_valid8 = 1'b0;
    stepCycle();
    checkOutput("n4_drained", out_valid4, 0);
    checkOutput("n8_cnt", xfer_cnt8, 8);

    // ---- back-to-back stream of all 16 indices ----
    $display("[TB] back-to-back stream");
    resetDut();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(i < 16, 4'(i), 1'b1);
      if (i < 16) checkOutput("seq_in_ready", in_ready, 1);
      if (i == 0) begin
        checkOutput("seq_latency", out_valid, 0);
      end else if (i <= 16) begin
        checkOutput("seq_valid", out_valid, 1);
        checkOutput("seq_data", out_data, 32'h1000 + i - 1);
      end
    end
    checkOutput("seq_end_valid", out_valid, 0);
    checkOutput("seq_xfer_cnt", xfer_cnt, 16);

    // ---- inputs ignored while in_valid is low ----
    $display("[TB] idle input changes");
    for (int i = 0; i < 4; i++) begin
      in_data[0 +: 16] = 16'(16'hBEE0 + i);
      applyStimulus(1'b0, 4'(i * 3), 1'b1);
      checkOutput("idle_valid", out_valid, 0);
    end
    checkOutput("idle_cnt", xfer_cnt, 16);
    in_data[0 +: 16] = 16'h1000;

    // ---- backpressure ----
    $display("[TB] backpressure");
    resetDut();
    applyStimulus(1'b1, 4'd5, 1'b0);
    applyStimulus(1'b1, 4'd10, 1'b0);
    checkOutput("bp_in_ready_low", in_ready, 0);
    checkOutput("bp_first_data", out_data, 16'h1005);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 4'd3, 1'b0);
      checkOutput("bp_hold_valid", out_valid, 1);
      checkOutput("bp_hold_data", out_data, 16'h1005);
      checkOutput("bp_hold_ready", in_ready, 0);
    end
    applyStimulus(1'b0, 4'd0, 1'b1);
    checkOutput("bp_second_data", out_data, 16'h100A);
    checkOutput("bp_second_valid", out_valid, 1);
    checkOutput("bp_cnt1", xfer_cnt, 1);
    applyStimulus(1'b0, 4'd0, 1'b1);
    checkOutput("bp_drained", out_valid, 0);
    checkOutput("bp_cnt2", xfer_cnt, 2);

    // ---- reset with both stages full ----
    $display("[TB] reset while full");
    applyStimulus(1'b1, 4'd7, 1'b0);
    applyStimulus(1'b1, 4'd9, 1'b0);
    checkOutput("full_in_ready", in_ready, 0);
    rst_n = 1'b0;
    applyStimulus(1'b1, 4'd11, 1'b1);
    checkOutput("rstfull_valid", out_valid, 0);
    checkOutput("rstfull_cnt", xfer_cnt, 0);
    checkOutput("rstfull_in_ready", in_ready, 1);
    checkOutput("rstfull_data", out_data, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'd0, 1'b1);
      checkOutput("rstfull_no_stale", out_valid, 0);
    end

    // ---- random handshakes against a scoreboard ----
    $display("[TB] random handshakes");
    resetDut();
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while (rcvd < 2000 && cyc < 40000) begin
      in_valid  = (sent < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_sel    = 4'($urandom_range(0, 15));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_valid && in_ready) begin
        q.push_back(16'(16'h1000 + in_sel));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checkOutput("rand_spurious", 1, 0);
        end else begin
          expWord = q.pop_front();
          checkOutput("rand_data", out_data, expWord);
        end
        rcvd++;
      end
      stepCycle();
      cyc++;
    end
    checkOutput("rand_count", rcvd, 2000);
    checkOutput("rand_leftover", q.size(), 0);
    checkOutput("rand_xfer_cnt", xfer_cnt, 2000);

    // ---- transfer counter wrap ----
    $display("[TB] counter wrap");
    resetDut();
    accepted  = 0;
    cyc       = 0;
    in_valid  = 1'b1;
    in_sel    = 4'd0;
    out_ready = 1'b1;
    while (accepted < 65535 && cyc < 70000) begin
      #1;
      if (in_ready) accepted++;
      stepCycle();
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("wrap_accepted", accepted, 65535);
    for (int i = 0; i < 4; i++) stepCycle();
    checkOutput("wrap_preload", xfer_cnt, 16'hFFFF);
    applyStimulus(1'b1, 4'd3, 1'b1);
    applyStimulus(1'b0, 4'd0, 1'b1);
    checkOutput("wrap_last_data", out_data, 16'h1003);
    checkOutput("wrap_before", xfer_cnt, 16'hFFFF);
    applyStimulus(1'b0, 4'd0, 1'b1);
    checkOutput("wrap_zero", xfer_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
